// File: rtl/fft_sink_framer_pkg.sv
// fft_sink_framer_pkg
// Shared definitions for the FFT sink framer: default frame length and
// sample width, the derived sample-index width, the sample type and the
// framer state encoding.
package fft_sink_framer_pkg;

    localparam int NFFT_DEF       = 512;
    localparam int DW_DEF         = 16;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int IDX_W          = $clog2(NFFT_DEF);

    typedef logic signed [DW_DEF-1:0] sample_t;

    // FILL   : FIFO empty, nothing to pop
    // STREAM : data pending and the sink is accepting
    // STALL  : data pending but the sink is holding off
    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

endpackage

// File: rtl/fft_sink_framer_fifo.sv
// sync_fifo
// Small synchronous FIFO with registered read data (one-cycle read latency).
// Pointers carry one extra wrap bit so that full and empty can be told apart.
// A write while full is accepted only if a read frees a slot in the same cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wr_en, din    write strobe and data
//   rd_en, dout   read strobe and registered read data
//   full, empty   occupancy status
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/fft_sink_framer.sv
// fft_sink_framer
// Selects the raw or filtered sample stream, buffers it in a skid FIFO that
// absorbs FFT sink backpressure, and frames the output into NFFT-sample
// packets with sop/eop markers. Samples lost to a full FIFO set a sticky ovf.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   din_raw, din_filt      candidate input samples
//   din_valid              one-cycle strobe per input sample
//   filtmx                 source select (0 raw, 1 filtered)
//   sink_ready             FFT core ready
//   sink_valid             output sample valid
//   sink_real, sink_imag   output sample (imaginary part always 0)
//   sink_sop, sink_eop     first / last sample of frame
//   frame_done             pulse coincident with sink_eop
//   ovf                    sticky overflow flag
//
// state     | meaning
// ST_FILL   | FIFO empty, no pop
// ST_STREAM | data pending and popping
// ST_STALL  | data pending, sink_ready low
module fft_sink_framer
    import fft_sink_framer_pkg::*;
#(
    parameter int NFFT       = NFFT_DEF,
    parameter int DW         = DW_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din_raw,
    input  logic [DW-1:0] din_filt,
    input  logic          din_valid,
    input  logic          filtmx,
    input  logic          sink_ready,
    output logic          sink_valid,
    output logic [DW-1:0] sink_real,
    output logic [DW-1:0] sink_imag,
    output logic          sink_sop,
    output logic          sink_eop,
    output logic          frame_done,
    output logic          ovf
);

    localparam int IW = $clog2(NFFT);

    logic [DW-1:0] sel_sample;
    logic [DW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic [IW-1:0] idx;
    state_t        state;

    // Select is sampled in the same cycle as din_valid, no pipelining.
    assign sel_sample = filtmx ? din_filt : din_raw;
    assign pop        = sink_ready && !fifo_empty;

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (din_valid),
        .din   (sel_sample),
        .rd_en (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The FIFO read register is the output data register: a pop in cycle N
    // presents the sample in cycle N+1, aligned with sink_valid below.
    assign sink_real = fifo_dout;
    assign sink_imag = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FILL;
            idx        <= '0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (!fifo_empty) begin
                        state <= sink_ready ? ST_STREAM : ST_STALL;
                    end
                end
                ST_STREAM: begin
                    if (fifo_empty) begin
                        state <= ST_FILL;
                    end else if (!sink_ready) begin
                        state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (fifo_empty) begin
                        state <= ST_FILL;
                    end else if (sink_ready) begin
                        state <= ST_STREAM;
                    end
                end
                default: state <= ST_FILL;
            endcase

            sink_valid <= pop;
            if (pop) begin
                sink_sop   <= (idx == '0);
                sink_eop   <= (idx == IW'(NFFT - 1));
                frame_done <= (idx == IW'(NFFT - 1));
                idx        <= idx + IW'(1);
            end else begin
                sink_sop   <= 1'b0;
                sink_eop   <= 1'b0;
                frame_done <= 1'b0;
            end

            // A write into a full FIFO survives only if a pop frees the slot.
            if (din_valid && fifo_full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_sink_framer.sv
module tb_fft_sink_framer;
    import fft_sink_framer_pkg::*;

    localparam int NF = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   din_raw = '0;
    logic [15:0]   din_filt = '0;
    logic          din_valid = 1'b0;
    logic          filtmx = 1'b0;
    logic          sink_ready = 1'b0;
    logic          sink_valid;
    logic [15:0]   sink_real;
    logic [15:0]   sink_imag;
    logic          sink_sop;
    logic          sink_eop;
    logic          frame_done;
    logic          ovf;

    int            checks = 0;
    int            failures = 0;
    int            out_cnt = 0;
    int            fd_cnt = 0;
    sample_t       sb[$];

    fft_sink_framer #(.NFFT(NF), .DW(16), .FIFO_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_raw    (din_raw),
        .din_filt   (din_filt),
        .din_valid  (din_valid),
        .filtmx     (filtmx),
        .sink_ready (sink_ready),
        .sink_valid (sink_valid),
        .sink_real  (sink_real),
        .sink_imag  (sink_imag),
        .sink_sop   (sink_sop),
        .sink_eop   (sink_eop),
        .frame_done (frame_done),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: expected data from the queue, framing from an
    // independent count of emitted samples.
    always @(negedge clk) begin
        if (!rst) begin
            if (sink_valid) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    sample_t e;
                    e = sb.pop_front();
                    check("sink_real", {16'h0, sink_real}, {16'h0, e});
                end
                check("sink_imag", {16'h0, sink_imag}, 32'd0);
                check("sink_sop", 32'(sink_sop), 32'((out_cnt % NF) == 0));
                check("sink_eop", 32'(sink_eop), 32'((out_cnt % NF) == NF - 1));
                check("frame_done", 32'(frame_done), 32'((out_cnt % NF) == NF - 1));
                if (frame_done) fd_cnt++;
                out_cnt++;
            end else begin
                check("idle_marks", {29'h0, sink_sop, sink_eop, frame_done}, 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        din_valid = 1'b0;
        sb.delete();
        out_cnt = 0;
        tick();
        check("rst_valid", 32'(sink_valid), 32'd0);
        check("rst_real", {16'h0, sink_real}, 32'd0);
        check("rst_marks", {29'h0, sink_sop, sink_eop, frame_done}, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        din_valid = 1'b0;
        sink_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        tick();
        do_reset();
        sink_ready = 1'b1;

        // Ramp frame, source raw, check two-cycle latency.
        for (int i = 0; i < NF; i++) begin
            din_valid = 1'b1;
            filtmx = 1'b0;
            din_raw = 16'(i);
            din_filt = 16'hFFFF;
            sb.push_back(sample_t'(i));
            tick();
            if (i == 0) check("latency_n1", 32'(sink_valid), 32'd0);
            if (i == 1) check("latency_n2", 32'(sink_valid), 32'd1);
        end
        drain();
        check("ovf_ramp", 32'(ovf), 32'd0);

        // Source switch mid-frame.
        for (int i = 0; i < NF; i++) begin
            din_valid = 1'b1;
            filtmx = (i >= 250);
            din_raw = 16'h0AAA;
            din_filt = 16'h0555;
            sb.push_back((i >= 250) ? sample_t'(16'h0555) : sample_t'(16'h0AAA));
            tick();
        end
        drain();

        // Stall for 20 writes: 16 buffered, 4 dropped.
        sink_ready = 1'b0;
        filtmx = 1'b0;
        for (int i = 0; i < 20; i++) begin
            din_valid = 1'b1;
            din_raw = 16'(1000 + i);
            if (i < 16) sb.push_back(sample_t'(1000 + i));
            tick();
        end
        din_valid = 1'b0;
        check("stall_ovf", 32'(ovf), 32'd1);
        check("stall_valid", 32'(sink_valid), 32'd0);
        drain();
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Two frames with alternating ready and sparse input.
        do_reset();
        fd_cnt = 0;
        for (int c = 0; c < 2 * 2 * NF; c++) begin
            din_valid = (c % 2 == 0);
            sink_ready = (c % 2 == 1);
            din_raw = 16'(c / 2);
            if (c % 2 == 0) sb.push_back(sample_t'(c / 2));
            tick();
        end
        drain();
        check("two_frames", fd_cnt, 32'd2);
        check("ovf_toggle", 32'(ovf), 32'd0);

        // Reset while output sample 300 of a frame is on the bus.
        sink_ready = 1'b1;
        for (int i = 0; i < 302; i++) begin
            din_valid = 1'b1;
            din_raw = 16'(i);
            sb.push_back(sample_t'(i));
            tick();
        end
        check("pre_rst_valid", 32'(sink_valid), 32'd1);
        do_reset();
        sink_ready = 1'b1;
        fd_cnt = 0;
        for (int i = 0; i < NF; i++) begin
            din_valid = 1'b1;
            din_raw = 16'(2000 + i);
            sb.push_back(sample_t'(2000 + i));
            tick();
        end
        drain();
        check("post_rst_frame", fd_cnt, 32'd1);

        // Full FIFO with simultaneous write and pop.
        sink_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din_valid = 1'b1;
            din_raw = 16'(3000 + i);
            sb.push_back(sample_t'(3000 + i));
            tick();
        end
        check("full_no_ovf", 32'(ovf), 32'd0);
        din_valid = 1'b1;
        sink_ready = 1'b1;
        din_raw = 16'd3016;
        sb.push_back(sample_t'(3016));
        tick();
        sink_ready = 1'b0;
        check("simul_no_ovf", 32'(ovf), 32'd0);
        din_raw = 16'd3017;
        tick();
        din_valid = 1'b0;
        check("still_full_ovf", 32'(ovf), 32'd1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_sink_framer.md
Name: fft_sink_framer

Overview:
- Sits downstream of the filter-mux control generator and directly upstream of the FFT core sink.
- Selects the raw or filtered sample stream per the filtmx control, buffers it in a small FIFO to absorb FFT sink_ready backpressure, and frames it as NFFT-sample packets with sop/eop markers.
- Flags any sample lost to FIFO overflow.

Parameters:
- NFFT, 512, samples per FFT frame (power of two).
- DW, 16, sample width in bits (signed two's complement).
- FIFO_DEPTH, 16, skid FIFO depth in entries (power of two, ≥4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- din_raw  in  DW  unfiltered sample
- din_filt  in  DW  filtered sample
- din_valid  in  1  one-cycle strobe per input sample
- filtmx  in  1  source select: 0 → din_raw, 1 → din_filt
- sink_ready  in  1  FFT core ready to accept a sample
- sink_valid  out  1  output sample valid
- sink_real  out  DW  output sample, real part
- sink_imag  out  DW  output sample, imaginary part; always 0
- sink_sop  out  1  first sample of frame
- sink_eop  out  1  last sample of frame
- frame_done  out  1  one-cycle pulse, coincident with sink_eop
- ovf  out  1  sticky overflow flag

Behaviour:
- Reset:
  - Clock is clk. Reset is rst, synchronous and active-high.
  - On reset: all outputs 0, FIFO emptied, sample index 0, ovf cleared.
  - Reset mid-frame discards the partial frame. The next output sample carries sop.
- Input side:
  - In a cycle with din_valid=1, the selected sample (filtmx ? din_filt : din_raw) is written to the FIFO.
  - filtmx is sampled in the same cycle as din_valid. There is no pipelining of the select.
  - If din_valid=1 and the FIFO is full, the sample is dropped and ovf is set. ovf stays 1 until rst.
  - Write to a full FIFO with a simultaneous pop is accepted: the pop frees the slot in the same cycle.
- Output side:
  - Pop condition: sink_ready=1 and FIFO not empty.
  - On a pop in cycle N, output registers load in cycle N+1: sink_valid=1, sink_real=popped data.
  - sink_valid is 0 in every cycle with no pop in the previous cycle. Data is held, but is don't-care when sink_valid=0.
  - Latency with an empty FIFO and sink_ready=1: a din_valid in cycle N gives sink_valid in cycle N+2 (write in N, pop in N+1, output registered in N+2).
- Framing:
  - Sample index idx (log2 NFFT bits) increments on each pop.
  - sink_sop=1 with the output sample popped at idx==0.
  - sink_eop=1 and frame_done=1 with the output sample popped at idx==NFFT-1.
  - idx wraps NFFT-1 → 0, so back-to-back frames run with no gap.
- FIFO:
  - Read and write pointers are one bit wider than the address.
  - full: address bits equal and MSBs differ. empty: pointers equal.
  - Occupancy never exceeds FIFO_DEPTH.
- State machine:
  - FILL: FIFO empty, no pop.
  - STREAM: pop active or data pending.
  - STALL: sink_ready=0 with data pending.
  - Transitions follow directly from the empty and sink_ready conditions. State affects only the internal status and the pop enable. Framing continues across STALL without reset of idx.

Decomposition:
- Shared package holds:
  - NFFT and DW defaults.
  - The derived IDX_W = log2(NFFT).
  - A sample typedef, signed [DW-1:0].
- One sub-module: sync_fifo.
  - Parameterised by width and depth.
  - Synchronous rst.
  - Ports: wr_en/din, rd_en/dout, full, empty. Registered dout, 1-cycle read latency.

Test Plan:
- Reset, then 512 samples with din_valid every cycle, ramp 0..511, filtmx=0, sink_ready=1 → 512 sink_valid pulses with sink_real=0..511, sop at value 0, eop and frame_done at value 511, ovf=0, first sink_valid 2 cycles after first din_valid.
- filtmx low for samples 0..249, high from 250, din_raw=0x0AAA, din_filt=0x0555 → output samples 0..249 are 0x0AAA, 250..511 are 0x0555, sink_imag always 0.
- sink_ready held low for 20 cycles while din_valid streams → exactly 16 samples buffered, 4 dropped, ovf=1 and stays 1. After ready returns, the 16 buffered values are emitted in order.
- 1024 consecutive samples with ready toggling 1/0 every cycle and din_valid every other cycle → no drops, two frames, sop at output sample 0 and 512, eop at 511 and 1023.
- rst pulsed for one cycle at output sample 300 → outputs 0 next cycle, ovf=0. The next accepted sample emerges with sink_sop=1, and eop falls 511 samples later.
- Full FIFO, with din_valid and sink_ready both 1 in the same cycle → no drop, ovf stays 0, occupancy stays 16.
